// File: rtl/seq_stream_checker.sv
// seq_stream_checker: checks a +1 (mod 2^WIDTH) count stream on enable, reports lock/errors; ports clk, reset_n, enable, data, clear -> locked, error, err_count, expected, last_bad, state
module seq_stream_checker #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  input  logic             clear,
  output logic             locked,
  output logic             error,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected,
  output logic [WIDTH-1:0] last_bad,
  output logic [1:0]       state
);
  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam logic [1:0] HUNT = 2'd0, SYNC = 2'd1, LOCKED = 2'd2;
  logic [1:0]    state_nx;
  logic [RW-1:0] run, run_inc, run_nx;
  logic          match, bad;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= HUNT;
      run       <= '0;
      error     <= 1'b0;
      err_count <= '0;
      expected  <= '0;
      last_bad  <= '0;
    end else begin
      state     <= state_nx;
      run       <= run_nx;
      error     <= bad;
      expected  <= enable ? data + 1'b1 : expected;
      err_count <= bad ? (clear ? ERR_W'(1) : (&err_count ? err_count : err_count + 1'b1))
                       : (clear ? '0 : err_count);
      last_bad  <= bad ? data : (clear ? '0 : last_bad);
    end
  end
  always_comb begin
    match    = data == expected;
    run_inc  = run + 1'b1;
    bad      = enable && state == LOCKED && !match;
    state_nx = !enable ? state
             : state == HUNT ? SYNC
             : state == LOCKED ? (match ? LOCKED : SYNC)
             : (match && run_inc == RW'(LOCK_COUNT)) ? LOCKED : SYNC;
    run_nx   = !enable ? run
             : (state == SYNC && match && run_inc != RW'(LOCK_COUNT)) ? run_inc : '0;
  end
  always_comb locked = state == LOCKED;
endmodule
